// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
//   Shared constants and types for the ROM read arbiter and its round-robin
//   picker. The ROM geometry matches blk_mem_gen_0 (18-bit address, 24-bit
//   word). The tag identifies which requester a pipelined read belongs to;
//   its id field is sized for the largest supported requester count, so one
//   tag type serves every NREQ.
// -----------------------------------------------------------------------------
package rom_arb_pkg;

  localparam int ROM_ADDR_W = 18;
  localparam int ROM_DATA_W = 24;
  localparam int MAX_NREQ   = 8;
  localparam int TAG_ID_W   = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } rom_tag_t;

  // Width of an encoded requester index; never zero so single-bit
  // configurations still get a legal vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans req starting at index ptr,
//   wrapping past NREQ-1 back to 0, and grants the first asserted request.
//
// Ports
//   req   in  NREQ   request vector
//   ptr   in  ID_W   highest-priority index this cycle (0..NREQ-1)
//   gnt   out NREQ   one-hot grant, all zero when req is zero
//   id    out ID_W   encoded index of the granted requester
//   any   out 1      some request is asserted (gnt is non-zero)
// -----------------------------------------------------------------------------
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id,
  output logic            any
);

  // hi_mask selects indices at or above ptr. If any of those request, the
  // lowest of them wins; otherwise the scan has wrapped, and the lowest
  // request overall wins. This equals a rotating scan from ptr.
  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] masked_req;
  logic [NREQ-1:0] pick_src;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign hi_mask[gi] = (ptr <= ID_W'(gi));
    end
  endgenerate

  assign masked_req = req & hi_mask;
  assign pick_src   = (|masked_req) ? masked_req : req;
  assign any        = |req;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    gnt = '0;
    id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        id     = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//   Shares the single-port synchronous ROM between NREQ read requesters.
//   One address is accepted per cycle via a combinational round-robin
//   grant; the returned word comes back ROM_LAT+2 cycles after the grant,
//   tagged with a one-hot rvalid for its requester. Returns are in grant
//   order and cannot be back-pressured.
//
// Ports
//   clk       in  1              system clock
//   rst_n     in  1              asynchronous active-low reset
//   req       in  NREQ           per-requester read request (level)
//   addr      in  NREQ*ADDR_W    flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       out NREQ           one-hot combinational grant
//   rvalid    out NREQ           one-hot single-cycle return strobe
//   rdata     out DATA_W         returned ROM word (registered)
//   rom_addr  out ADDR_W         registered ROM address
//   rom_dout  in  DATA_W         ROM read data
// -----------------------------------------------------------------------------
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] addr,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_dout
);

  localparam int ID_W  = id_width(NREQ);
  // One stage covers the rom_addr register, ROM_LAT more cover the ROM.
  localparam int DEPTH = 1 + ROM_LAT;

  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [NREQ-1:0]   rvalid_reg, rvalid_next;
  rom_tag_t          tag_pipe_reg [DEPTH];
  rom_tag_t          tag_in;
  rom_tag_t          tag_last;

  logic [NREQ-1:0]   pick_gnt;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic [ADDR_W-1:0] addr_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
      assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .id  (pick_id),
    .any (pick_any)
  );

  // Masking with rst_n keeps requesters from treating a request as
  // accepted while the registers are being held in reset.
  assign gnt = pick_gnt & {NREQ{rst_n}};

  assign tag_last = tag_pipe_reg[DEPTH-1];

  always_comb begin
    ptr_next      = ptr_reg;
    rom_addr_next = rom_addr_reg;
    tag_in        = '0;
    if (pick_any) begin
      rom_addr_next = addr_arr[pick_id];
      ptr_next      = (pick_id == ID_W'(NREQ - 1)) ? '0 : pick_id + ID_W'(1);
      tag_in.valid  = 1'b1;
      tag_in.id     = TAG_ID_W'(pick_id);
    end
  end

  // rdata holds between returns so a requester may sample it late.
  always_comb begin
    rvalid_next = '0;
    rdata_next  = rdata_reg;
    if (tag_last.valid) begin
      rvalid_next = NREQ'(1) << tag_last.id;
      rdata_next  = rom_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg      <= '0;
      rom_addr_reg <= '0;
      rdata_reg    <= '0;
      rvalid_reg   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_pipe_reg[i] <= '0;
      end
    end else begin
      ptr_reg         <= ptr_next;
      rom_addr_reg    <= rom_addr_next;
      rdata_reg       <= rdata_next;
      rvalid_reg      <= rvalid_next;
      tag_pipe_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        tag_pipe_reg[i] <= tag_pipe_reg[i-1];
      end
    end
  end

  assign rom_addr = rom_addr_reg;
  assign rdata    = rdata_reg;
  assign rvalid   = rvalid_reg;

endmodule
